// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register sitting between decode (register-file read) and
// execute. It holds one instruction at a time and handshakes in both
// directions with valid/ready.
//
// Write-back data is forwarded into the operands in two places:
//   - when the instruction is captured, and
//   - while it is held in a stall.
// The register file only re-reads when its address changes, so a write that
// lands underneath a held instruction would otherwise be lost.
//
// Ports
//   clk, rst_n               clock; asynchronous active-low reset
//   id_valid / id_ready      upstream handshake. id_ready does not depend on
//                            id_valid.
//   id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_ctrl
//                            decoded instruction payload
//   wb_regwrite, wb_rd, wb_data
//                            write-back port, used for bypass
//   flush                    kills the held instruction and any incoming one
//   perf_clr                 synchronous clear of stall_cnt
//   ex_valid / ex_ready      downstream handshake
//   ex_*                     registered payload; the operands are
//                            bypass-corrected
//   stall_cnt                saturating count of cycles with
//                            ex_valid & !ex_ready
// ---------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              perf_clr,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              ex_valid_reg;
    logic [XLEN-1:0]   ex_pc_reg;
    logic [4:0]        ex_rs1_reg;
    logic [4:0]        ex_rs2_reg;
    logic [4:0]        ex_rd_reg;
    logic [XLEN-1:0]   ex_imm_reg;
    logic [CTRL_W-1:0] ex_ctrl_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  stall_cnt_next;

    logic load;
    logic held;

    // A flush always frees the stage, so the incoming instruction can be
    // accepted and then dropped in the same cycle.
    assign id_ready = !ex_valid_reg | ex_ready | flush;

    // Flush wins over a load. While held, load is impossible because
    // id_ready is low unless flush is also high.
    assign load = id_valid & id_ready & !flush;
    assign held = ex_valid_reg & !ex_ready & !flush;

    // Per-operand views, so that one generate loop can build both operands.
    logic [4:0]      id_rs_idx  [2];
    logic [XLEN-1:0] id_rs_val  [2];
    logic [4:0]      ex_rs_idx  [2];
    assign id_rs_idx[0] = id_rs1;
    assign id_rs_idx[1] = id_rs2;
    assign id_rs_val[0] = id_rs1_data;
    assign id_rs_val[1] = id_rs2_data;
    assign ex_rs_idx[0] = ex_rs1_reg;
    assign ex_rs_idx[1] = ex_rs2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [XLEN-1:0] op_reg;
            logic [XLEN-1:0] op_next;
            logic            held_hit;

            // A write-back to x0 must never reach a held operand, because
            // the register file does not hardwire x0 to zero.
            assign held_hit = held & wb_regwrite & (wb_rd != 5'd0)
                            & (wb_rd == ex_rs_idx[gi]);

            always_comb begin
                op_next = op_reg;
                if (load) begin
                    if (id_rs_idx[gi] == 5'd0)
                        op_next = '0;
                    else if (wb_regwrite && (wb_rd == id_rs_idx[gi]))
                        op_next = wb_data;
                    else
                        op_next = id_rs_val[gi];
                end else if (held_hit) begin
                    op_next = wb_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    op_reg <= '0;
                else
                    op_reg <= op_next;
            end
        end
    endgenerate

    assign ex_rs1_data = g_op[0].op_reg;
    assign ex_rs2_data = g_op[1].op_reg;

    // Valid bit and non-operand payload. The payload only changes on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg <= 1'b0;
            ex_pc_reg    <= '0;
            ex_rs1_reg   <= '0;
            ex_rs2_reg   <= '0;
            ex_rd_reg    <= '0;
            ex_imm_reg   <= '0;
            ex_ctrl_reg  <= '0;
        end else begin
            if (flush)
                ex_valid_reg <= 1'b0;
            else if (load)
                ex_valid_reg <= 1'b1;
            else if (ex_ready)
                ex_valid_reg <= 1'b0;

            if (load) begin
                ex_pc_reg   <= id_pc;
                ex_rs1_reg  <= id_rs1;
                ex_rs2_reg  <= id_rs2;
                ex_rd_reg   <= id_rd;
                ex_imm_reg  <= id_imm;
                ex_ctrl_reg <= id_ctrl;
            end
        end
    end

    // The stall counter counts any cycle where execute holds and does not
    // consume, including a cycle that is flushed.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (perf_clr)
            stall_cnt_next = '0;
        else if (ex_valid_reg && !ex_ready && (stall_cnt_reg != CNT_MAX))
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else
            stall_cnt_reg <= stall_cnt_next;
    end

    assign ex_valid  = ex_valid_reg;
    assign ex_pc     = ex_pc_reg;
    assign ex_rs1    = ex_rs1_reg;
    assign ex_rs2    = ex_rs2_reg;
    assign ex_rd     = ex_rd_reg;
    assign ex_imm    = ex_imm_reg;
    assign ex_ctrl   = ex_ctrl_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe
// Table-driven bench for id_ex_pipe, with stall_cnt narrowed to 4 bits.
//
// Each vector drives one cycle of inputs and carries the expected state after
// the next rising edge. That expectation is pushed to a scoreboard queue when
// the vector is driven, and popped and compared once the edge has happened.
//
// The non-operand payload of every instruction is a fixed function of its PC:
//   rd   = pc[6:2]
//   imm  = pc ^ 0xFFFF0000
//   ctrl = pc[15:0] + 0x0101
// So the expected ex_rd, ex_imm and ex_ctrl follow from the expected PC.
//
// Hand-written sequences cover stall-counter saturation, perf_clr, and an
// asynchronous reset applied mid-stall.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_regwrite;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush, perf_clr;
    logic              ex_valid, ex_ready;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    id_ex_pipe #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .perf_clr(perf_clr),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [31:0] d1;
        logic [4:0]  rs2;
        logic [31:0] d2;
        logic        wbe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        fl;
        logic        pclr;
        logic        er;
        logic        e_rdy;
        logic        e_v;
        logic [31:0] e_pc;
        logic [4:0]  e_rs1;
        logic [31:0] e_d1;
        logic [4:0]  e_rs2;
        logic [31:0] e_d2;
        logic [3:0]  e_st;
    } vec_t;

    typedef struct {
        logic        e_v;
        logic [31:0] e_pc;
        logic [4:0]  e_rs1;
        logic [31:0] e_d1;
        logic [4:0]  e_rs2;
        logic [31:0] e_d2;
        logic [3:0]  e_st;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mkv(
        input logic iv, input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
        input logic [4:0] rs2, input logic [31:0] d2, input logic wbe, input logic [4:0] wbrd,
        input logic [31:0] wbd, input logic fl, input logic pclr, input logic er,
        input logic e_rdy, input logic e_v, input logic [31:0] e_pc, input logic [4:0] e_rs1,
        input logic [31:0] e_d1, input logic [4:0] e_rs2, input logic [31:0] e_d2,
        input logic [3:0] e_st);
        vec_t v;
        v.iv = iv; v.pc = pc; v.rs1 = rs1; v.d1 = d1; v.rs2 = rs2; v.d2 = d2;
        v.wbe = wbe; v.wbrd = wbrd; v.wbd = wbd; v.fl = fl; v.pclr = pclr; v.er = er;
        v.e_rdy = e_rdy; v.e_v = e_v; v.e_pc = e_pc; v.e_rs1 = e_rs1; v.e_d1 = e_d1;
        v.e_rs2 = e_rs2; v.e_d2 = e_d2; v.e_st = e_st;
        return v;
    endfunction

    task automatic idle_inputs();
        id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_ctrl = '0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; perf_clr = 1'b0; ex_ready = 1'b0;
    endtask

    // Drive one vector: check the combinational id_ready, queue the
    // expectation, then compare the registered state after the edge.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        id_valid = v.iv; id_pc = v.pc; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_rd = v.pc[6:2]; id_rs1_data = v.d1; id_rs2_data = v.d2;
        id_imm = v.pc ^ 32'hFFFF0000; id_ctrl = v.pc[15:0] + 16'h0101;
        wb_regwrite = v.wbe; wb_rd = v.wbrd; wb_data = v.wbd;
        flush = v.fl; perf_clr = v.pclr; ex_ready = v.er;
        #1;
        chk($sformatf("v%0d id_ready", idx), {31'd0, id_ready}, {31'd0, v.e_rdy});
        e.e_v = v.e_v; e.e_pc = v.e_pc; e.e_rs1 = v.e_rs1; e.e_d1 = v.e_d1;
        e.e_rs2 = v.e_rs2; e.e_d2 = v.e_d2; e.e_st = v.e_st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d scoreboard_empty", idx), 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            chk($sformatf("v%0d ex_valid", idx), {31'd0, ex_valid}, {31'd0, got.e_v});
            chk($sformatf("v%0d ex_pc", idx), ex_pc, got.e_pc);
            chk($sformatf("v%0d ex_rs1", idx), {27'd0, ex_rs1}, {27'd0, got.e_rs1});
            chk($sformatf("v%0d ex_rs1_data", idx), ex_rs1_data, got.e_d1);
            chk($sformatf("v%0d ex_rs2", idx), {27'd0, ex_rs2}, {27'd0, got.e_rs2});
            chk($sformatf("v%0d ex_rs2_data", idx), ex_rs2_data, got.e_d2);
            chk($sformatf("v%0d ex_rd", idx), {27'd0, ex_rd}, {27'd0, got.e_pc[6:2]});
            chk($sformatf("v%0d ex_imm", idx), ex_imm, got.e_pc ^ 32'hFFFF0000);
            chk($sformatf("v%0d ex_ctrl", idx), {16'd0, ex_ctrl}, {16'd0, got.e_pc[15:0] + 16'h0101});
            chk($sformatf("v%0d stall_cnt", idx), {28'd0, stall_cnt}, {28'd0, got.e_st});
            $display("txn %0d pc=%h ex_valid=%0b ex_pc=%h rs1d=%h rs2d=%h stall=%0d",
                     idx, id_pc, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, stall_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming of four instructions at full rate.
        vecs.push_back(mkv(1, 32'h00, 1, 32'h100, 2, 32'h200, 0, 0, 0, 0, 0, 1,  1, 1, 32'h00, 1, 32'h100, 2, 32'h200, 0));
        vecs.push_back(mkv(1, 32'h04, 1, 32'h104, 2, 32'h204, 0, 0, 0, 0, 0, 1,  1, 1, 32'h04, 1, 32'h104, 2, 32'h204, 0));
        vecs.push_back(mkv(1, 32'h08, 1, 32'h108, 2, 32'h208, 0, 0, 0, 0, 0, 1,  1, 1, 32'h08, 1, 32'h108, 2, 32'h208, 0));
        vecs.push_back(mkv(1, 32'h0C, 1, 32'h10C, 2, 32'h20C, 0, 0, 0, 0, 0, 1,  1, 1, 32'h0C, 1, 32'h10C, 2, 32'h20C, 0));
        // Drain: valid drops and the payload holds.
        vecs.push_back(mkv(0, 32'h99, 3, 32'h333, 4, 32'h444, 0, 0, 0, 0, 0, 1,  1, 0, 32'h0C, 1, 32'h10C, 2, 32'h20C, 0));
        // Capture bypass on rs1, followed by a stall.
        vecs.push_back(mkv(1, 32'h20, 5, 32'h11, 7, 32'h77, 1, 5, 32'hAA, 0, 0, 0,  1, 1, 32'h20, 5, 32'hAA, 7, 32'h77, 0));
        // Held: the new instruction is refused.
        vecs.push_back(mkv(1, 32'h24, 0, 32'h55, 9, 32'h99, 0, 0, 0, 0, 0, 0,  0, 1, 32'h20, 5, 32'hAA, 7, 32'h77, 1));
        // Held bypass on rs1, then on rs2 (x7 = 0x1234).
        vecs.push_back(mkv(0, 32'h00, 0, 32'h0, 0, 32'h0, 1, 5, 32'hBB, 0, 0, 0,  0, 1, 32'h20, 5, 32'hBB, 7, 32'h77, 2));
        vecs.push_back(mkv(0, 32'h00, 0, 32'h0, 0, 32'h0, 1, 7, 32'h1234, 0, 0, 0,  0, 1, 32'h20, 5, 32'hBB, 7, 32'h1234, 3));
        // Release and load in the same cycle; capture with rs1=x0 gives 0
        // even though a write-back to x0 is active.
        vecs.push_back(mkv(1, 32'h24, 0, 32'h55, 9, 32'h99, 1, 0, 32'hEE, 0, 0, 1,  1, 1, 32'h24, 0, 32'h0, 9, 32'h99, 3));
        // Held x0: a write-back to x0 must not reach the held rs1.
        vecs.push_back(mkv(0, 32'h00, 0, 32'h0, 0, 32'h0, 1, 0, 32'hDEAD, 0, 0, 0,  0, 1, 32'h24, 0, 32'h0, 9, 32'h99, 4));
        vecs.push_back(mkv(0, 32'h00, 0, 32'h0, 0, 32'h0, 1, 9, 32'h999, 0, 0, 0,  0, 1, 32'h24, 0, 32'h0, 9, 32'h999, 5));
        // Flush while held with an incoming instruction.
        vecs.push_back(mkv(1, 32'h40, 3, 32'h33, 4, 32'h44, 0, 0, 0, 1, 0, 0,  1, 0, 32'h24, 0, 32'h0, 9, 32'h999, 6));
        // perf_clr.
        vecs.push_back(mkv(0, 32'h00, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 1, 0,  1, 0, 32'h24, 0, 32'h0, 9, 32'h999, 0));
        // Both operands name x4 and both update while held.
        vecs.push_back(mkv(1, 32'h50, 4, 32'h1, 4, 32'h2, 0, 0, 0, 0, 0, 0,  1, 1, 32'h50, 4, 32'h1, 4, 32'h2, 0));
        vecs.push_back(mkv(0, 32'h00, 0, 32'h0, 0, 32'h0, 1, 4, 32'hCAFE, 0, 0, 0,  0, 1, 32'h50, 4, 32'hCAFE, 4, 32'hCAFE, 1));
        // Flush while being consumed, with an incoming instruction.
        vecs.push_back(mkv(1, 32'h60, 6, 32'h66, 6, 32'h66, 0, 0, 0, 1, 0, 1,  1, 0, 32'h50, 4, 32'hCAFE, 4, 32'hCAFE, 1));
        // Capture bypass on rs2 = x0 as well as rs1.
        vecs.push_back(mkv(1, 32'h64, 8, 32'h88, 0, 32'h5, 1, 8, 32'hF0, 0, 0, 1,  1, 1, 32'h64, 8, 32'hF0, 0, 32'h0, 1));

        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset ex_pc", ex_pc, 32'd0);
        chk("reset stall_cnt", {28'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Saturation: hold the last instruction. stall_cnt is 1 now, so 14
        // more held cycles reach 15, and further cycles must not wrap.
        @(negedge clk);
        idle_inputs();
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 14) chk("sat reach15", {28'd0, stall_cnt}, 32'd15);
        end
        chk("sat hold15", {28'd0, stall_cnt}, 32'd15);
        chk("sat ex_valid", {31'd0, ex_valid}, 32'd1);
        $display("txn sat stall_cnt=%0d", stall_cnt);
        @(negedge clk);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("perf_clr priority", {28'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        perf_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("count after clr", {28'd0, stall_cnt}, 32'd1);
        $display("txn perf_clr stall_cnt=%0d", stall_cnt);

        // Asynchronous reset in the middle of a stall, away from any edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("async ex_pc", ex_pc, 32'd0);
        chk("async ex_rs1_data", ex_rs1_data, 32'd0);
        chk("async ex_rs2_data", ex_rs2_data, 32'd0);
        chk("async ex_imm", ex_imm, 32'd0);
        chk("async ex_ctrl", {16'd0, ex_ctrl}, 32'd0);
        chk("async ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("async stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("async id_ready", {31'd0, id_ready}, 32'd1);
        $display("txn async_reset ex_valid=%0b stall_cnt=%0d", ex_valid, stall_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset ex_valid", {31'd0, ex_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
